pipelined_main: RTL and testbench
=================================

Name: pipelined_main

Overview:
- Minimal 3-stage in-order pipelined processor (IF, ID, EX/WB) with an internal instruction ROM and a 32x32 register file.
- Exposes only the result of the most recent executed instruction on ALU_output.
- Top-level block of the pipelined-processor design; the bench drives only clock and reset.

Parameters:
- DATA_W, 32, datapath and register width.
- IMEM_DEPTH, 16, instruction ROM words; PC wraps modulo IMEM_DEPTH.
- REG_COUNT, 32, register file entries (5-bit indices).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- ALU_output  output  32  registered EX/WB result of the last non-NOP instruction.

Behaviour:
- Instruction format: opcode[31:26], rd[25:21], rs1[20:16], rs2[15:11]; bits [10:0] ignored.
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR.
  - 6 SLT: signed compare, result 1 or 0.
  - 7 SLL: rs1 << rs2[4:0].
  - 8..63 execute as NOP.
- Arithmetic wraps modulo 2^32; no flags and no exceptions.
- Reset (async, while reset=0):
  - PC=0.
  - IF/ID and ID/EX pipeline registers hold NOP (all zeros).
  - ALU_output=0.
  - Register file: reg[i]=i for i=0..31.
  - Reset asserted mid-program aborts all in-flight instructions; the program restarts at PC 0 after release.
- IF stage: IF/ID.instr <= imem[PC]; PC <= (PC+1) mod IMEM_DEPTH. No stalls; branches are not supported.
- ID stage:
  - Reads rs1 and rs2 from the register file.
  - Latches opcode, rd and both operands into ID/EX.
  - Forwarding: if the instruction in EX writes a nonzero rd equal to rs1 or rs2, the current ALU result replaces the register-file value for that operand.
- EX/WB stage:
  - ALU computes from the ID/EX operands.
  - On the same edge, for a non-NOP opcode: ALU_output <= result, and reg[rd] <= result when rd != 0.
  - NOP: ALU_output and the register file are unchanged.
- r0: always reads 0; writes to r0 are discarded (ALU_output still updates).
- Latency: the instruction fetched at edge N appears on ALU_output after edge N+2. Throughput is one instruction per cycle.
- Default ROM contents (remaining words are NOP):
  - I0: ADD r10,r1,r2
  - I1: SUB r11,r10,r3
  - I2: OR r12,r4,r8
  - I3: AND r13,r12,r5
  - I4: XOR r14,r13,r7
  - I5: SLT r15,r1,r2
- Wrap-around: after word 15 the PC returns to 0 and the program re-executes with the updated register values.

Decomposition:
- Shared package pm_pkg holds:
  - opcode constants (OP_NOP..OP_SLL);
  - DATA_W;
  - instruction field bit positions;
  - a typedef for the ID/EX pipeline record (opcode, rd, op_a, op_b).
- One natural sub-module: pm_alu, which is purely combinational (opcode, a, b -> result).
- The register file, ROM and pipeline registers stay in pipelined_main.

Test Plan:
- Reset held low, then released before the first rising edge -> ALU_output=0 and stays 0 until two edges after the first fetch.
- Default program, edges counted from the first edge after release -> ALU_output sequence 3, 0, 12, 4, 3, 1, then holds 1 through the NOPs. The 0 at I1 proves EX->ID forwarding.
- Assert reset mid-program (after I3's result) -> ALU_output=0 immediately, asynchronously. After release the sequence restarts at 3 (register file back to reg[i]=i).
- ROM with SUB r1,r0,r1 then SLT r2,r1,r0 -> results 0xFFFFFFFF, then 1 (signed compare).
- ROM with ADD r0,r5,r6 then ADD r3,r0,r0 -> results 11 then 0 (r0 never written; no forwarding from rd=0).
- ROM with opcode 0x3F plus SLL r4,r1,r5 -> the undefined opcode leaves ALU_output unchanged; SLL yields 32.

Source files
------------

// File: rtl/pm_pkg.sv
// Shared definitions for the pipelined_main processor: opcodes, instruction
// field positions, the ID/EX pipeline record and the default program image.
package pm_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_NOP = 6'd0;
  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;
  localparam logic [5:0] OP_AND = 6'd3;
  localparam logic [5:0] OP_OR  = 6'd4;
  localparam logic [5:0] OP_XOR = 6'd5;
  localparam logic [5:0] OP_SLT = 6'd6;
  localparam logic [5:0] OP_SLL = 6'd7;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;

  typedef struct packed {
    logic [5:0]        opcode;
    logic [4:0]        rd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
  } idex_t;

  // Opcodes 1..7 do real work; everything else behaves as a NOP.
  function automatic logic is_active(input logic [5:0] opcode);
    return (opcode >= OP_ADD) && (opcode <= OP_SLL);
  endfunction

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  // Word 0 sits in the least significant 32 bits.
  localparam logic [16*DATA_W-1:0] DEFAULT_ROM = {
    {10{32'd0}},
    enc(OP_SLT, 5'd15, 5'd1,  5'd2),
    enc(OP_XOR, 5'd14, 5'd13, 5'd7),
    enc(OP_AND, 5'd13, 5'd12, 5'd5),
    enc(OP_OR,  5'd12, 5'd4,  5'd8),
    enc(OP_SUB, 5'd11, 5'd10, 5'd3),
    enc(OP_ADD, 5'd10, 5'd1,  5'd2)
  };

endpackage

// File: rtl/pipelined_main_alu.sv
// Purely combinational ALU for the EX/WB stage.
module pm_alu
  import pm_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  // Select the operation; undefined opcodes yield 0 but are never committed.
  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
      OP_SLL:  result = a << b[4:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_main.sv
// Three-stage in-order processor (IF, ID, EX/WB) with an internal ROM, a
// 32-entry register file and EX->ID forwarding. Only the last committed
// result is visible, on ALU_output.
module pipelined_main
  import pm_pkg::*;
#(
  parameter int IMEM_DEPTH = 16,
  parameter int REG_COUNT  = 32,
  parameter logic [IMEM_DEPTH*DATA_W-1:0] ROM_IMAGE = DEFAULT_ROM
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] ALU_output
);

  localparam int PC_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [PC_W-1:0]   pc_reg;
  logic [31:0]       ifid_reg;
  idex_t             idex_reg;
  logic [DATA_W-1:0] alu_out_reg;
  logic [DATA_W-1:0] rf_reg [REG_COUNT];
  logic [31:0]       imem [IMEM_DEPTH];

  logic [5:0]        id_opcode;
  logic [4:0]        id_rd, id_rs1, id_rs2;
  logic [DATA_W-1:0] id_a, id_b;
  logic [DATA_W-1:0] alu_result;
  logic              ex_active;
  logic              ex_writes;
  logic              unused_low_bits;

  // ROM image unpacked into addressable words.
  generate
    for (genvar gi = 0; gi < IMEM_DEPTH; gi++) begin : g_rom
      assign imem[gi] = ROM_IMAGE[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign id_opcode       = ifid_reg[OPC_HI:OPC_LO];
  assign id_rd           = ifid_reg[RD_HI:RD_LO];
  assign id_rs1          = ifid_reg[RS1_HI:RS1_LO];
  assign id_rs2          = ifid_reg[RS2_HI:RS2_LO];
  assign unused_low_bits = ^ifid_reg[RS2_LO-1:0];

  assign ex_active = is_active(idex_reg.opcode);
  assign ex_writes = ex_active && (idex_reg.rd != 5'd0);

  // Operand fetch with forwarding of the result being committed this cycle.
  always_comb begin
    id_a = (id_rs1 == 5'd0) ? '0 : rf_reg[id_rs1];
    id_b = (id_rs2 == 5'd0) ? '0 : rf_reg[id_rs2];
    if (ex_writes && (idex_reg.rd == id_rs1)) id_a = alu_result;
    if (ex_writes && (idex_reg.rd == id_rs2)) id_b = alu_result;
  end

  pm_alu u_alu (
    .opcode (idex_reg.opcode),
    .a      (idex_reg.op_a),
    .b      (idex_reg.op_b),
    .result (alu_result)
  );

  // IF and ID stages: fetch, advance PC with wrap, latch decoded record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg   <= '0;
      ifid_reg <= '0;
      idex_reg <= '0;
    end else begin
      ifid_reg <= imem[pc_reg];
      pc_reg   <= (pc_reg == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc_reg + 1'b1;
      idex_reg <= '{opcode: id_opcode, rd: id_rd, op_a: id_a, op_b: id_b};
    end
  end

  // EX/WB commit: visible result updates on every real instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alu_out_reg <= '0;
    else if (ex_active) alu_out_reg <= alu_result;
  end

  // Register file write-back; r0 is never written so it stays 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf_reg[i] <= DATA_W'(i);
    end else if (ex_writes) begin
      rf_reg[idex_reg.rd] <= alu_result;
    end
  end

  assign ALU_output = alu_out_reg;

endmodule

// File: tb/tb_pipelined_main.sv
// Scoreboard bench: two instances (default program and a corner-case program)
// share clock and a randomly pulsed reset; an ISA-level sequential model
// predicts each cycle's ALU_output and a monitor compares.
module tb_pipelined_main;

  function automatic logic [31:0] tb_enc(input int op, input int rd, input int a,
                                         input int b, input int lo);
    return 32'((op << 26) | (rd << 21) | (a << 16) | (b << 11) | lo);
  endfunction

  // Default program written out independently of the design package.
  localparam logic [511:0] DEF_ROM = {
    {10{32'd0}},
    tb_enc(6, 15, 1, 2, 0), tb_enc(5, 14, 13, 7, 0), tb_enc(3, 13, 12, 5, 0),
    tb_enc(4, 12, 4, 8, 0), tb_enc(2, 11, 10, 3, 0), tb_enc(1, 10, 1, 2, 0)
  };

  // Corner cases: signed SLT, r0 writes, undefined opcodes, SLL, ignored bits.
  localparam logic [511:0] TEST_ROM = {
    tb_enc(7, 30, 30, 31, 0),      // 15 SLL r30,r30,r31
    tb_enc(8, 3, 3, 3, 0),         // 14 undefined -> NOP
    tb_enc(4, 0, 7, 1, 0),         // 13 OR r0,r7,r1
    tb_enc(3, 7, 31, 30, 0),       // 12 AND r7,r31,r30
    tb_enc(2, 5, 5, 31, 0),        // 11 SUB r5,r5,r31
    tb_enc(1, 31, 31, 9, 0),       // 10 ADD r31,r31,r9
    tb_enc(6, 8, 9, 8, 0),         //  9 SLT r8,r9,r8
    tb_enc(5, 9, 9, 1, 0),         //  8 XOR r9,r9,r1
    tb_enc(7, 6, 2, 9, 11'h7FF),   //  7 SLL r6,r2,r9 with junk low bits
    tb_enc(0, 7, 7, 7, 11'h155),   //  6 NOP with junk fields
    tb_enc(7, 4, 1, 5, 0),         //  5 SLL r4,r1,r5
    tb_enc(63, 1, 2, 3, 0),        //  4 opcode 0x3F -> NOP
    tb_enc(1, 3, 0, 0, 0),         //  3 ADD r3,r0,r0
    tb_enc(1, 0, 5, 6, 0),         //  2 ADD r0,r5,r6
    tb_enc(6, 2, 1, 0, 0),         //  1 SLT r2,r1,r0
    tb_enc(2, 1, 0, 1, 0)          //  0 SUB r1,r0,r1
  };

  logic        clk;
  logic        rst_n;
  logic [31:0] out_def, out_tst;

  pipelined_main dut_def (.clk(clk), .reset(rst_n), .ALU_output(out_def));
  pipelined_main #(.ROM_IMAGE(TEST_ROM)) dut_tst (.clk(clk), .reset(rst_n), .ALU_output(out_tst));

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q_def [$];
  logic [31:0] q_tst [$];
  logic [31:0] rom   [2][16];
  logic [31:0] mregs [2][32];
  logic [31:0] mout  [2];
  int          edges = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Execute one instruction sequentially against the architectural state.
  task automatic model_exec(input int d, input logic [31:0] w);
    int op, rd;
    logic [31:0] a, b, r;
    op = int'(w >> 26);
    rd = int'((w >> 21) & 32'h1F);
    a  = mregs[d][(w >> 16) & 32'h1F];
    b  = mregs[d][(w >> 11) & 32'h1F];
    r  = 0;
    case (op)
      1: r = a + b;
      2: r = a - b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7: r = a << (b % 32);
      default: return;
    endcase
    mout[d] = r;
    if (rd != 0) mregs[d][rd] = r;
  endtask

  // Model: the word fetched on edge k after release retires on edge k+2.
  initial begin
    for (int i = 0; i < 16; i++) begin
      rom[0][i] = DEF_ROM[i*32 +: 32];
      rom[1][i] = TEST_ROM[i*32 +: 32];
    end
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        edges = 0;
        for (int d = 0; d < 2; d++) begin
          mout[d] = 0;
          for (int i = 0; i < 32; i++) mregs[d][i] = i;
        end
      end else begin
        edges++;
        if (edges >= 3)
          for (int d = 0; d < 2; d++) model_exec(d, rom[d][(edges - 3) % 16]);
      end
      q_def.push_back(mout[0]);
      q_tst.push_back(mout[1]);
    end
  end

  // Monitor: one expected value per instance per cycle.
  initial begin
    logic [31:0] e0, e1;
    forever begin
      @(negedge clk);
      if (q_def.size() > 0 && q_tst.size() > 0) begin
        e0 = q_def.pop_front();
        e1 = q_tst.pop_front();
        n_vec += 2;
        $display("vec %0d t=%0t def=%h tst=%h", n_vec, $time, out_def, out_tst);
        if (out_def !== e0) begin
          n_err++;
          $display("FAIL def_prog got %h expected %h at %0t", out_def, e0, $time);
        end
        if (out_tst !== e1) begin
          n_err++;
          $display("FAIL tst_prog got %h expected %h at %0t", out_tst, e1, $time);
        end
      end
    end
  end

  // Stimulus: random run lengths between asynchronous reset pulses.
  initial begin
    int run;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int seg = 0; seg < 8; seg++) begin
      run = (seg == 0) ? 40 : int'($urandom_range(4, 45));
      repeat (run) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec += 2;
      $display("vec %0d async reset def=%h tst=%h", n_vec, out_def, out_tst);
      if (out_def !== 32'd0) begin
        n_err++;
        $display("FAIL async_rst_def got %h expected 00000000", out_def);
      end
      if (out_tst !== 32'd0) begin
        n_err++;
        $display("FAIL async_rst_tst got %h expected 00000000", out_tst);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #2 rst_n = 1'b1;
    end
    repeat (40) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
